// File: rtl/frame_buf_pkg.sv
// rtl/frame_buf_pkg.sv - shared state encodings, strobe polarities and sizing helper for frame buffer feeders
package frame_buf_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pix_capture_packer.sv
// rtl/pix_capture_packer.sv - packs framed pixel stream into frame buffer words, capped at FRAME_WORDS per frame
// Optional drop counter port enabled by PIX_CAPTURE_DROP_CNT_EN.
module pix_capture_packer
  import frame_buf_pkg::*;
#(
  parameter int PIX_WIDTH    = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH,
  parameter int FRAME_WORDS  = 500,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  pix_valid,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  wr_en_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  frame_done,
  output logic                  busy
`ifdef PIX_CAPTURE_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  drop_cnt
`endif
);

  localparam int LANE_W = (clog2(PIX_PER_WORD) < 1) ? 1 : clog2(PIX_PER_WORD);
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
  localparam logic [CNT_WIDTH-1:0] WORD_CAP  = CNT_WIDTH'(FRAME_WORDS);

  logic [1:0]                                 state;
  logic [LANE_W-1:0]                          lane_idx;
  logic [PIX_PER_WORD-1:0][PIX_WIDTH-1:0]     stage;
  logic [PIX_PER_WORD-1:0][PIX_WIDTH-1:0]     stage_next;
  logic                                       cap_hit;
  logic                                       accept;
  logic                                       lane_full;
  logic [LANE_W-1:0]                          lane_next;
  logic [CNT_WIDTH-1:0]                       words_next;
  logic                                       flush_needed;

  // Lookahead of this cycle's pixel so a frame_end coinciding with a pixel sees its effect.
  always_comb begin
    cap_hit    = (word_cnt >= WORD_CAP);
    accept     = pix_valid && !cap_hit;
    lane_full  = accept && (lane_idx == LAST_LANE);
    stage_next = stage;
    if (accept) stage_next[lane_idx] = pix_data;
    if (lane_full)   lane_next = '0;
    else if (accept) lane_next = lane_idx + LANE_W'(1);
    else             lane_next = lane_idx;
    words_next   = word_cnt + CNT_WIDTH'(lane_full);
    flush_needed = (lane_next != '0) && (words_next < WORD_CAP);
  end

  assign busy = (state == ST_CAPTURE) || (state == ST_FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_en_out  <= DEASSERT_L;
      data_out   <= '0;
      word_cnt   <= '0;
      frame_done <= DEASSERT_H;
      lane_idx   <= '0;
      stage      <= '0;
    end else begin
      wr_en_out  <= DEASSERT_L;
      frame_done <= DEASSERT_H;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state    <= ST_CAPTURE;
            lane_idx <= '0;
            word_cnt <= '0;
            stage    <= '0;
          end
        end
        ST_CAPTURE: begin
          if (frame_start) begin
            lane_idx <= '0;
            word_cnt <= '0;
            stage    <= '0;
          end else begin
            if (accept) begin
              // Clearing on wrap keeps upper lanes zero for a later partial flush.
              stage    <= lane_full ? '0 : stage_next;
              lane_idx <= lane_next;
            end
            if (lane_full) begin
              data_out  <= stage_next;
              wr_en_out <= ASSERT_L;
              word_cnt  <= words_next;
            end
            if (frame_end) state <= flush_needed ? ST_FLUSH : ST_DONE;
          end
        end
        ST_FLUSH: begin
          if (frame_start) begin
            state    <= ST_CAPTURE;
            lane_idx <= '0;
            word_cnt <= '0;
            stage    <= '0;
          end else begin
            data_out  <= stage;
            wr_en_out <= ASSERT_L;
            word_cnt  <= word_cnt + CNT_WIDTH'(1);
            lane_idx  <= '0;
            stage     <= '0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          frame_done <= ASSERT_H;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PIX_CAPTURE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      drop_cnt <= '0;
    end else if ((state == ST_CAPTURE) && pix_valid && cap_hit && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pix_capture_packer.sv
// tb/tb_pix_capture_packer.sv - self-checking bench for pix_capture_packer (optional PIX_CAPTURE_DROP_CNT_EN)
module tb_pix_capture_packer;

  localparam int FW = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start, frame_end, pix_valid;
  logic [7:0]  pix_data;
  logic        wr_en_out;
  logic [31:0] data_out;
  logic [15:0] word_cnt;
  logic        frame_done, busy;
`ifdef PIX_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  pix_capture_packer #(
    .PIX_WIDTH(8), .DATA_WIDTH(32), .FRAME_WORDS(FW), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .wr_en_out(wr_en_out),
    .data_out(data_out), .word_cnt(word_cnt), .frame_done(frame_done), .busy(busy)
`ifdef PIX_CAPTURE_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fs, fe, pv;
    logic [7:0]  pix;
    logic        exp_wr;
    logic [31:0] exp_data;
    logic [15:0] exp_wc;
    logic        exp_done, exp_busy;
  } vec_t;

  vec_t        vecs [19];
  logic [31:0] exp_q [$];
  int          vec_cnt = 0, miss_cnt = 0;
  int          strobes = 0, dones = 0;
  logic [31:0] m_word;
  int          m_idx, m_words;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en_out === 1'b0) begin
      strobes++;
      if (exp_q.size() == 0) chk("stray_write", data_out, 32'hxxxxxxxx);
      else chk("write_data", data_out, exp_q.pop_front());
    end
    if (frame_done === 1'b1) dones++;
  end

  // Drive one cycle and advance a reference packing model alongside it.
  task automatic cyc(input logic s, input logic e, input logic v, input logic [7:0] p);
    frame_start = s; frame_end = e; pix_valid = v; pix_data = p;
    if (s) begin
      m_word = '0; m_idx = 0; m_words = 0;
    end else begin
      if (v && m_words < FW) begin
        m_word[m_idx*8 +: 8] = p;
        m_idx++;
        if (m_idx == 4) begin
          exp_q.push_back(m_word); m_word = '0; m_idx = 0; m_words++;
        end
      end
      if (e && m_idx != 0 && m_words < FW) begin
        exp_q.push_back(m_word); m_word = '0; m_idx = 0; m_words++;
      end
    end
    @(posedge clk); #1;
    frame_start = 0; frame_end = 0; pix_valid = 0; pix_data = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input string name);
    int start_d, n;
    start_d = dones; n = 0;
    while (dones == start_d && n < 10) begin
      @(posedge clk); #1; n++;
    end
    idle(2);
    chk(name, dones - start_d, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int s0;
    vecs[0]  = '{1, 0, 0, 8'h00, 1, 32'h00000000, 16'd0, 0, 1};
    vecs[1]  = '{0, 0, 1, 8'h11, 1, 32'h00000000, 16'd0, 0, 1};
    vecs[2]  = '{0, 0, 1, 8'h22, 1, 32'h00000000, 16'd0, 0, 1};
    vecs[3]  = '{0, 0, 1, 8'h33, 1, 32'h00000000, 16'd0, 0, 1};
    vecs[4]  = '{0, 0, 1, 8'h44, 0, 32'h44332211, 16'd1, 0, 1};
    vecs[5]  = '{0, 0, 0, 8'h00, 1, 32'h44332211, 16'd1, 0, 1};
    vecs[6]  = '{0, 1, 0, 8'h00, 1, 32'h44332211, 16'd1, 0, 0};
    vecs[7]  = '{0, 0, 0, 8'h00, 1, 32'h44332211, 16'd1, 1, 0};
    vecs[8]  = '{0, 0, 0, 8'h00, 1, 32'h44332211, 16'd1, 0, 0};
    vecs[9]  = '{1, 0, 0, 8'h00, 1, 32'h44332211, 16'd0, 0, 1};
    vecs[10] = '{0, 0, 1, 8'h11, 1, 32'h44332211, 16'd0, 0, 1};
    vecs[11] = '{0, 0, 1, 8'h22, 1, 32'h44332211, 16'd0, 0, 1};
    vecs[12] = '{0, 0, 1, 8'h33, 1, 32'h44332211, 16'd0, 0, 1};
    vecs[13] = '{0, 0, 1, 8'h44, 0, 32'h44332211, 16'd1, 0, 1};
    vecs[14] = '{0, 0, 1, 8'h55, 1, 32'h44332211, 16'd1, 0, 1};
    vecs[15] = '{0, 1, 1, 8'h66, 1, 32'h44332211, 16'd1, 0, 1};
    vecs[16] = '{0, 0, 0, 8'h00, 0, 32'h00006655, 16'd2, 0, 0};
    vecs[17] = '{0, 0, 0, 8'h00, 1, 32'h00006655, 16'd2, 1, 0};
    vecs[18] = '{0, 0, 0, 8'h00, 1, 32'h00006655, 16'd2, 0, 0};

    reset = 1; frame_start = 0; frame_end = 0; pix_valid = 0; pix_data = 0;
    m_word = '0; m_idx = 0; m_words = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en_out, 1);
    chk("rst_data", data_out, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
`ifdef PIX_CAPTURE_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    reset = 0;
    idle(1);

    // Full word then a six-pixel frame needing a partial flush.
    for (int i = 0; i < 19; i++) begin
      frame_start = vecs[i].fs; frame_end = vecs[i].fe;
      pix_valid = vecs[i].pv; pix_data = vecs[i].pix;
      if (vecs[i].exp_wr == 1'b0) exp_q.push_back(vecs[i].exp_data);
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_en", i), wr_en_out, vecs[i].exp_wr);
      chk($sformatf("v%0d_data", i), data_out, vecs[i].exp_data);
      chk($sformatf("v%0d_word_cnt", i), word_cnt, vecs[i].exp_wc);
      chk($sformatf("v%0d_frame_done", i), frame_done, vecs[i].exp_done);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
    end
    frame_start = 0; frame_end = 0; pix_valid = 0; pix_data = 0;
    idle(1);

    // Gapped pixels pack identically.
    s0 = strobes;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'h11); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 8'h22); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 8'h33); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 8'h44); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    wait_done("gap_frame_done");
    chk("gap_strobes", strobes - s0, 1);
    chk("gap_word_cnt", word_cnt, 1);

    // Frame cap: twelve pixels against a two-word limit.
    s0 = strobes;
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 12; i++) cyc(0, 0, 1, 8'(i));
    cyc(0, 1, 0, 0);
    wait_done("cap_frame_done");
    chk("cap_strobes", strobes - s0, 2);
    chk("cap_word_cnt", word_cnt, 2);
`ifdef PIX_CAPTURE_DROP_CNT_EN
    chk("cap_drop_cnt", drop_cnt, 4);
`endif

    // Reset mid-frame discards the partial word.
    s0 = strobes;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'h91); cyc(0, 0, 1, 8'h92);
    reset = 1;
    @(posedge clk); #1;
    chk("midrst_wr_en", wr_en_out, 1);
    chk("midrst_word_cnt", word_cnt, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_busy", busy, 0);
    reset = 0;
    m_word = '0; m_idx = 0; m_words = 0;
    idle(1);
    chk("midrst_strobes", strobes - s0, 0);
    s0 = strobes;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'hA1); cyc(0, 0, 1, 8'hA2); cyc(0, 0, 1, 8'hA3); cyc(0, 0, 1, 8'hA4);
    cyc(0, 1, 0, 0);
    wait_done("postrst_frame_done");
    chk("postrst_strobes", strobes - s0, 1);
    chk("postrst_word_cnt", word_cnt, 1);

    // Restart mid-word; frame_start outranks a simultaneous frame_end.
    s0 = strobes;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'hC1); cyc(0, 0, 1, 8'hC2); cyc(0, 0, 1, 8'hC3);
    cyc(1, 1, 0, 0);
    chk("restart_busy", busy, 1);
    chk("restart_word_cnt", word_cnt, 0);
    cyc(0, 0, 1, 8'hB1); cyc(0, 0, 1, 8'hB2); cyc(0, 0, 1, 8'hB3); cyc(0, 0, 1, 8'hB4);
    cyc(0, 1, 0, 0);
    wait_done("restart_frame_done");
    chk("restart_strobes", strobes - s0, 1);
    chk("restart_word_cnt_end", word_cnt, 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
